// File: rtl/isa_pkg.sv
// Shared RV32I definitions: opcode constants, instruction format enumeration, field bundle.
// Latency: n/a (types, constants and pure combinational helpers only).
// Backpressure: n/a.
package isa_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

    // One instruction's worth of fields as carried through the encoder pipeline.
    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } fields_t;

    function automatic logic opcode_known(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_AUIPC, OPC_STORE, OPC_OP,
            OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

    // Unknown opcodes fall back to I-format so a deterministic word is still produced.
    function automatic fmt_e opcode_fmt(input logic [6:0] opc);
        case (opc)
            OPC_OP:             return FMT_R;
            OPC_STORE:          return FMT_S;
            OPC_BRANCH:         return FMT_B;
            OPC_LUI, OPC_AUIPC: return FMT_U;
            OPC_JAL:            return FMT_J;
            default:            return FMT_I;
        endcase
    endfunction

    // True when v is the sign-extension of v[msb], i.e. bits [31:msb] are all equal.
    function automatic logic fits_signed(input logic [31:0] v, input int msb);
        logic [31:0] t;
        t = 32'($signed(v) >>> msb);
        return (t == '0) || (t == '1);
    endfunction

endpackage

// File: rtl/inst_pack.sv
// Packs RV32I fields into a 32-bit word and flags immediates/opcodes that do not fit.
// Latency: purely combinational.
// Backpressure: none; the enclosing pipeline qualifies the result.
module inst_pack
    import isa_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] inst,
    output logic        err
);

    fmt_e       fmt;
    logic [4:0] rs1_eff;

    // Format-driven bit placement plus range check; the truncated word is always produced.
    always_comb begin
        fmt     = opcode_fmt(opcode);
        // LUI has no rs1; zero it so the word matches what the decoder reports.
        rs1_eff = (opcode == OPC_LUI) ? 5'd0 : rs1;
        inst    = '0;
        err     = !opcode_known(opcode);
        case (fmt)
            FMT_R: begin
                inst = {funct7, rs2, rs1_eff, funct3, rd, opcode};
            end
            FMT_I: begin
                inst = {imm[11:0], rs1_eff, funct3, rd, opcode};
                if (!fits_signed(imm, 11)) err = 1'b1;
            end
            FMT_S: begin
                inst = {imm[11:5], rs2, rs1_eff, funct3, imm[4:0], opcode};
                if (!fits_signed(imm, 11)) err = 1'b1;
            end
            FMT_B: begin
                inst = {imm[12], imm[10:5], rs2, rs1_eff, funct3, imm[4:1], imm[11], opcode};
                if (!fits_signed(imm, 12) || imm[0]) err = 1'b1;
            end
            FMT_U: begin
                inst = {imm[31:12], rd, opcode};
                if (imm[11:0] != 12'd0) err = 1'b1;
            end
            FMT_J: begin
                inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                if (!fits_signed(imm, 20) || imm[0]) err = 1'b1;
            end
            default: begin
                inst = '0;
                err  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/inst_encode.sv
// RV32I instruction encoder: two-stage valid/ready pipeline around inst_pack, plus delivered-word counter.
// Latency: 2 cycles from acceptance to out_valid; 1 word/cycle sustained with out_ready high.
// Backpressure: each stage advances only if the next is empty or draining; in_ready = !s1 || !s2 || out_ready.
module inst_encode
    import isa_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] inst,
    output logic        err,
    output logic [15:0] count
);

    logic        s1_valid_q, s1_valid_d;
    fields_t     s1_q, s1_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] inst_q, inst_d;
    logic        err_q, err_d;
    logic [15:0] count_q, count_d;

    logic        s2_rdy;
    logic [31:0] pk_inst;
    logic        pk_err;

    inst_pack u_pack (
        .opcode (s1_q.opcode),
        .rd     (s1_q.rd),
        .rs1    (s1_q.rs1),
        .rs2    (s1_q.rs2),
        .funct3 (s1_q.funct3),
        .funct7 (s1_q.funct7),
        .imm    (s1_q.imm),
        .inst   (pk_inst),
        .err    (pk_err)
    );

    // Stage 2 can take a word when it is empty or its word leaves this cycle.
    assign s2_rdy   = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_rdy;

    // Next-state for both stages and the handshake counter.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_d        = s1_q;
        out_valid_d = out_valid_q;
        inst_d      = inst_q;
        err_d       = err_q;
        count_d     = count_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d = '{opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
                         funct3: funct3, funct7: funct7, imm: imm};
            end
        end
        // Output word only changes when stage 2 may move, so it is held while stalled.
        if (s2_rdy) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                inst_d = pk_inst;
                err_d  = pk_err;
            end
        end
        if (out_valid_q && out_ready) count_d = count_q + 16'd1;
    end

    // Pipeline and counter state; reset discards anything in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            inst_q      <= '0;
            err_q       <= 1'b0;
            count_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_q        <= s1_d;
            out_valid_q <= out_valid_d;
            inst_q      <= inst_d;
            err_q       <= err_d;
            count_q     <= count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign inst      = inst_q;
    assign err       = err_q;
    assign count     = count_q;

endmodule

// File: tb/tb_inst_encode.sv
// Self-checking bench for inst_encode: directed vectors, backpressure, randomized traffic, reset.
// Latency: n/a.
// Backpressure: driven randomly by the bench.
module tb_inst_encode;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  opcode = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [31:0] imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] inst;
    logic        err;
    logic [15:0] count;

    int tests = 0;
    int fails = 0;
    int count_model = 0;

    typedef struct packed {
        logic        known;
        logic        err;
        logic [31:0] inst;
    } exp_t;

    exp_t sb[$];

    logic [6:0] ops [11] = '{7'h33, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
                             7'h13, 7'h67, 7'h03, 7'h0F, 7'h73};

    inst_encode dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inst      (inst),
        .err       (err),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Reference encoder built from the ISA rules with shifts/masks and signed ranges.
    function automatic exp_t model(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                                   input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] im);
        exp_t e;
        int   si;
        logic [31:0] base;
        si = int'($signed(im));
        e.known = 1'b1;
        e.err   = 1'b0;
        e.inst  = '0;
        base = 32'(op) | (32'(d) << 7) | (32'(f3) << 12) | (32'(s1) << 15);
        case (op)
            7'h33: e.inst = base | (32'(s2) << 20) | (32'(f7) << 25);
            7'h13, 7'h67, 7'h03, 7'h0F, 7'h73: begin
                e.inst = base | ((im & 32'hFFF) << 20);
                e.err  = (si < -2048) || (si > 2047);
            end
            7'h23: begin
                e.inst = 32'(op) | ((im & 32'h1F) << 7) | (32'(f3) << 12) | (32'(s1) << 15)
                       | (32'(s2) << 20) | (((im >> 5) & 32'h7F) << 25);
                e.err  = (si < -2048) || (si > 2047);
            end
            7'h63: begin
                e.inst = 32'(op) | (((im >> 11) & 32'h1) << 7) | (((im >> 1) & 32'hF) << 8)
                       | (32'(f3) << 12) | (32'(s1) << 15) | (32'(s2) << 20)
                       | (((im >> 5) & 32'h3F) << 25) | (((im >> 12) & 32'h1) << 31);
                e.err  = (si < -4096) || (si > 4095) || (si % 2 != 0);
            end
            7'h37, 7'h17: begin
                e.inst = 32'(op) | (32'(d) << 7) | (im & 32'hFFFFF000);
                e.err  = (im % 4096) != 0;
            end
            7'h6F: begin
                e.inst = 32'(op) | (32'(d) << 7) | (((im >> 12) & 32'hFF) << 12)
                       | (((im >> 11) & 32'h1) << 20) | (((im >> 1) & 32'h3FF) << 21)
                       | (((im >> 20) & 32'h1) << 31);
                e.err  = (si < -1048576) || (si > 1048575) || (si % 2 != 0);
            end
            default: begin
                e.known = 1'b0;
                e.err   = 1'b1;
            end
        endcase
        return e;
    endfunction

    task automatic drive_fields(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                                input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] im);
        opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    endtask

    task automatic random_fields();
        logic [6:0]  op;
        int          v;
        logic [31:0] im;
        if ($urandom_range(0, 15) == 0) begin
            case ($urandom_range(0, 2))
                0:       op = 7'h7F;
                1:       op = 7'h00;
                default: op = 7'h5B;
            endcase
        end else begin
            op = ops[$urandom_range(0, 10)];
        end
        v = int'($urandom_range(0, 8191)) - 4096;
        case ($urandom_range(0, 4))
            0:       im = $urandom;
            1:       im = 32'(v);
            2:       im = 32'(v) & ~32'h1;
            3:       im = 32'(v) << 12;
            default: im = (32'(v) << 9) & ~32'h1;
        endcase
        drive_fields(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), im);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        resetn    = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        sb.delete();
        count_model = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests++;
        if (inst !== 32'h0 || err !== 1'b0) begin fails++; $display("FAIL reset_inst_err: got %h/%b expected 0/0", inst, err); end
        tests++;
        if (count !== 16'h0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count); end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        count_model = 0;
        sb.delete();
    endtask

    task automatic check_vec(input string nm, input logic [6:0] op, input logic [4:0] d,
                             input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [31:0] im,
                             input logic [31:0] exp_inst, input logic exp_err, input bit chk_inst);
        @(negedge clk);
        drive_fields(op, d, s1, s2, f3, f7, im);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL %s_in_ready: got %b expected 1", nm, in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL %s_early: out_valid got %b expected 0 after 1 cycle", nm, out_valid); end
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b1) begin fails++; $display("FAIL %s_latency: out_valid got %b expected 1 after 2 cycles", nm, out_valid); end
        tests++;
        if (err !== exp_err) begin fails++; $display("FAIL %s_err: got %b expected %b", nm, err, exp_err); end
        if (chk_inst) begin
            tests++;
            if (inst !== exp_inst) begin fails++; $display("FAIL %s_inst: got %h expected %h", nm, inst, exp_inst); end
        end
        @(posedge clk);
        count_model++;
        #1;
        tests++;
        if (count !== 16'(count_model)) begin fails++; $display("FAIL %s_count: got %0d expected %0d", nm, count, count_model); end
    endtask

    task automatic test_vectors();
        check_vec("addi",   7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,          32'h00500093, 1'b0, 1'b1);
        check_vec("sw",     7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,          32'h0020A423, 1'b0, 1'b1);
        check_vec("jal",    7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC,   32'hFFDFF06F, 1'b0, 1'b1);
        check_vec("lui",    7'h37, 5'd5, 5'd7, 5'd0, 3'd0, 7'd0, 32'h12345000,   32'h123452B7, 1'b0, 1'b1);
        check_vec("lui_e",  7'h37, 5'd5, 5'd7, 5'd0, 3'd0, 7'd0, 32'h12345001,   32'h123452B7, 1'b1, 1'b1);
        check_vec("br_odd", 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,          32'h0,        1'b1, 1'b0);
        check_vec("br_big", 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096,       32'h0,        1'b1, 1'b0);
        check_vec("br_neg", 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF000,   32'h80000063, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        exp_t exp_q[$];
        int   idx = 0;
        int   got = 0;
        int   cyc = 0;
        logic [6:0]  w_op [4];
        logic [31:0] w_im [4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            w_op[i] = ops[$urandom_range(0, 10)];
            w_im[i] = 32'(int'($urandom_range(0, 2047)) - 1024) << (w_op[i] == 7'h37 || w_op[i] == 7'h17 ? 12 : 1);
            exp_q.push_back(model(w_op[i], 5'(i + 1), 5'(i + 3), 5'(i + 5), 3'(i), 7'(i * 9), w_im[i]));
        end
        for (int c = 0; c < 3; c++) begin
            bit acc;
            @(negedge clk);
            out_ready = 1'b0;
            drive_fields(w_op[idx], 5'(idx + 1), 5'(idx + 3), 5'(idx + 5), 3'(idx), 7'(idx * 9), w_im[idx]);
            in_valid = 1'b1;
            #1;
            acc = in_ready;
            @(posedge clk);
            if (acc) idx++;
        end
        tests++;
        if (idx !== 2) begin fails++; $display("FAIL bp_accepts: got %0d accepts expected 2 while stalled", idx); end
        @(negedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready: got %b expected 0 with both stages full", in_ready); end
        while (got < 4 && cyc < 30) begin
            cyc++;
            if (cyc > 1) @(negedge clk);
            out_ready = 1'b1;
            if (idx < 4) begin
                drive_fields(w_op[idx], 5'(idx + 1), 5'(idx + 3), 5'(idx + 5), 3'(idx), 7'(idx * 9), w_im[idx]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid === 1'b1) begin
                tests++;
                if (inst !== exp_q[got].inst || err !== exp_q[got].err) begin
                    fails++;
                    $display("FAIL bp_word%0d: got %h/%b expected %h/%b", got, inst, err, exp_q[got].inst, exp_q[got].err);
                end
                got++;
            end
            if (in_valid && in_ready) idx++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tests++;
        if (got !== 4) begin fails++; $display("FAIL bp_drain: got %0d words expected 4 within bound", got); end
        tests++;
        if (count !== 16'd4) begin fails++; $display("FAIL bp_count: got %0d expected 4", count); end
        count_model = 4;
    endtask

    task automatic test_random();
        bit          have = 1'b0;
        bit          prev_stall = 1'b0;
        logic [31:0] prev_inst = '0;
        logic        prev_err = 1'b0;
        exp_t        e;
        int          cyc = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!have && $urandom_range(0, 2) != 0) begin
                random_fields();
                have = 1'b1;
            end
            in_valid  = have;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (prev_stall) begin
                tests++;
                if (out_valid !== 1'b1 || inst !== prev_inst || err !== prev_err) begin
                    fails++;
                    $display("FAIL rnd_hold: got %b/%h/%b expected 1/%h/%b", out_valid, inst, err, prev_inst, prev_err);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_inst  = inst;
            prev_err   = err;
            if (out_valid && out_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL rnd_extra: unexpected word %h", inst);
                end else begin
                    e = sb.pop_front();
                    if (err !== e.err || (e.known && inst !== e.inst)) begin
                        fails++;
                        $display("FAIL rnd_word: got %h/%b expected %h/%b", inst, err, e.inst, e.err);
                    end
                end
                count_model++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(opcode, rd, rs1, rs2, funct3, funct7, imm));
                have = 1'b0;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb.size() != 0 && cyc < 20) begin
            cyc++;
            #1;
            if (out_valid) begin
                e = sb.pop_front();
                tests++;
                if (err !== e.err || (e.known && inst !== e.inst)) begin
                    fails++;
                    $display("FAIL rnd_drain_word: got %h/%b expected %h/%b", inst, err, e.inst, e.err);
                end
                count_model++;
            end
            @(negedge clk);
        end
        #1;
        tests++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rnd_drain: %0d words left, out_valid %b, expected 0/0", sb.size(), out_valid);
        end
        tests++;
        if (count !== 16'(count_model)) begin fails++; $display("FAIL rnd_count: got %0d expected %0d", count, count_model); end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            random_fields();
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_inflight: out_valid got %b expected 1 before reset", out_valid); end
        #1;
        resetn = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_out_valid: got %b expected 0 during reset", out_valid); end
        tests++;
        if (count !== 16'h0) begin fails++; $display("FAIL mid_count: got %0d expected 0 during reset", count); end
        @(negedge clk);
        resetn    = 1'b1;
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_in_ready: got %b expected 1 after release", in_ready); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            tests++;
            if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_stale: out_valid got %b expected 0 in cycle %0d", out_valid, c); end
        end
        tests++;
        if (count !== 16'h0) begin fails++; $display("FAIL mid_count_after: got %0d expected 0", count); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_vectors();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
